// File: rtl/traffic_pkg.sv
// Shared constants for the traffic conflict monitor: light codes, fault codes,
// approach indices, monitor state and a lowest-set-index helper.
package traffic_pkg;

    localparam logic [2:0] RED    = 3'b000;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;

    localparam logic [2:0] FC_NONE         = 3'd0;
    localparam logic [2:0] FC_ILLEGAL      = 3'd1;
    localparam logic [2:0] FC_CONFLICT     = 3'd2;
    localparam logic [2:0] FC_SEQ          = 3'd3;
    localparam logic [2:0] FC_SHORT_GREEN  = 3'd4;
    localparam logic [2:0] FC_SHORT_YELLOW = 3'd5;
    localparam logic [2:0] FC_STUCK        = 3'd6;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_S = 2'd1;
    localparam logic [1:0] DIR_E = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } mon_state_t;

    function automatic logic [1:0] first_idx(input logic [3:0] v);
        first_idx = DIR_N;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) first_idx = 2'(i);
        end
    endfunction

endpackage

// File: rtl/light_seq_checker.sv
// Per-approach checks: illegal code, bad colour order and too-short green/yellow,
// judged against the shared duration of the previous light vector.
module light_seq_checker
    import traffic_pkg::*;
#(
    parameter int DW         = 7,
    parameter int MIN_GREEN  = 6,
    parameter int MIN_YELLOW = 3
) (
    input  logic [2:0]    prev,
    input  logic [2:0]    cur,
    input  logic [DW-1:0] dur,
    output logic          illegal,
    output logic          seq,
    output logic          short_green,
    output logic          short_yellow
);

    localparam logic [DW-1:0] MIN_G = DW'(MIN_GREEN);
    localparam logic [DW-1:0] MIN_Y = DW'(MIN_YELLOW);

    always_comb begin
        illegal      = (cur != RED) && (cur != GREEN) && (cur != YELLOW);
        seq          = ((prev == GREEN)  && (cur == RED))   ||
                       ((prev == YELLOW) && (cur == GREEN)) ||
                       ((prev == RED)    && (cur == YELLOW));
        short_green  = (prev == GREEN)  && (cur != GREEN)  && (dur < MIN_G);
        short_yellow = (prev == YELLOW) && (cur != YELLOW) && (dur < MIN_Y);
    end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety monitor for the four-approach light bus; latches the first violation and
// forces all-red until cleared. Define TRAFFIC_FAULT_LOG_EN to add the fault_cnt output.
module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN  = 6,
    parameter int MIN_YELLOW = 3,
    parameter int WDOG       = 64,
    parameter int ARM_DLY    = 2
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic [2:0] n_light,
    input  logic [2:0] s_light,
    input  logic [2:0] e_light,
    input  logic [2:0] w_light,
    input  logic       fault_clr,
    output logic [2:0] safe_n_light,
    output logic [2:0] safe_s_light,
    output logic [2:0] safe_e_light,
    output logic [2:0] safe_w_light,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_dir
`ifdef TRAFFIC_FAULT_LOG_EN
    ,
    output logic [7:0] fault_cnt
`endif
);

    localparam int DW = $clog2(WDOG + 1);
    localparam int AW = $clog2(ARM_DLY + 1);
    localparam logic [DW-1:0] WDOG_D  = DW'(WDOG);
    localparam logic [AW-1:0] ARM_END = AW'(ARM_DLY - 1);

    mon_state_t      state;
    logic [AW-1:0]   arm_cnt;
    logic [DW-1:0]   dur;
    logic [3:0][2:0] cur_a;
    logic [3:0][2:0] prev_a;
    logic [3:0][2:0] safe_a;

    logic [3:0] ill, sq, sg, sy, non_red;
    logic       vec_same, conflict, stuck, viol, all_red;
    logic [DW-1:0] dur_inc;
    logic [2:0] viol_code;
    logic [1:0] viol_dir;

    // Index 0 is north so lowest-index reporting follows N, S, E, W order.
    assign cur_a[0] = n_light;
    assign cur_a[1] = s_light;
    assign cur_a[2] = e_light;
    assign cur_a[3] = w_light;

    for (genvar i = 0; i < 4; i++) begin : g_chk
        light_seq_checker #(
            .DW        (DW),
            .MIN_GREEN (MIN_GREEN),
            .MIN_YELLOW(MIN_YELLOW)
        ) u_chk (
            .prev        (prev_a[i]),
            .cur         (cur_a[i]),
            .dur         (dur),
            .illegal     (ill[i]),
            .seq         (sq[i]),
            .short_green (sg[i]),
            .short_yellow(sy[i])
        );
        assign non_red[i] = (cur_a[i] != RED);
    end

    always_comb begin
        vec_same  = (cur_a == prev_a);
        dur_inc   = (dur == WDOG_D) ? dur : dur + DW'(1);
        conflict  = ((non_red & (non_red - 4'd1)) != 4'd0);
        stuck     = vec_same && (dur_inc == WDOG_D);
        all_red   = (non_red == 4'd0);
        viol      = 1'b1;
        viol_code = FC_NONE;
        viol_dir  = DIR_N;
        if (|ill) begin
            viol_code = FC_ILLEGAL;
            viol_dir  = first_idx(ill);
        end else if (conflict) begin
            viol_code = FC_CONFLICT;
            viol_dir  = first_idx(non_red);
        end else if (|sq) begin
            viol_code = FC_SEQ;
            viol_dir  = first_idx(sq);
        end else if (|sg) begin
            viol_code = FC_SHORT_GREEN;
            viol_dir  = first_idx(sg);
        end else if (|sy) begin
            viol_code = FC_SHORT_YELLOW;
            viol_dir  = first_idx(sy);
        end else if (stuck) begin
            viol_code = FC_STUCK;
        end else begin
            viol = 1'b0;
        end
    end

`ifdef TRAFFIC_FAULT_LOG_EN
    logic [7:0] fault_cnt_q;
    assign fault_cnt = fault_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_a) begin
            fault_cnt_q <= 8'd0;
        end else if ((state == ST_RUN) && viol && (fault_cnt_q != 8'hFF)) begin
            fault_cnt_q <= fault_cnt_q + 8'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_a) begin
            state      <= ST_ARM;
            arm_cnt    <= '0;
            dur        <= '0;
            prev_a     <= '0;
            safe_a     <= '0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            fault_dir  <= DIR_N;
        end else begin
            case (state)
                ST_ARM: begin
                    safe_a <= '0;
                    if (arm_cnt == ARM_END) begin
                        state   <= ST_RUN;
                        arm_cnt <= '0;
                        prev_a  <= cur_a;
                        dur     <= DW'(1);
                    end else begin
                        arm_cnt <= arm_cnt + AW'(1);
                    end
                end
                ST_RUN: begin
                    if (viol) begin
                        state      <= ST_FAULT;
                        safe_a     <= '0;
                        fault      <= 1'b1;
                        fault_code <= viol_code;
                        fault_dir  <= viol_dir;
                    end else begin
                        safe_a <= cur_a;
                        if (vec_same) begin
                            dur <= dur_inc;
                        end else begin
                            dur    <= DW'(1);
                            prev_a <= cur_a;
                        end
                    end
                end
                ST_FAULT: begin
                    safe_a <= '0;
                    // Lamps must already be dark before the operator may re-arm.
                    if (fault_clr && all_red) begin
                        state      <= ST_ARM;
                        arm_cnt    <= '0;
                        fault      <= 1'b0;
                        fault_code <= FC_NONE;
                        fault_dir  <= DIR_N;
                    end
                end
                default: state <= ST_ARM;
            endcase
        end
    end

    assign safe_n_light = safe_a[0];
    assign safe_s_light = safe_a[1];
    assign safe_e_light = safe_a[2];
    assign safe_w_light = safe_a[3];

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor: each step pushes its expected
// outputs {fault, code, dir, safe lights} and checks them after the clock edge.
module tb_traffic_conflict_monitor;

    localparam logic [2:0] R = 3'b000;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;

    logic       clk = 1'b0;
    logic       rst_a;
    logic [2:0] n_light, s_light, e_light, w_light;
    logic       fault_clr;
    logic [2:0] safe_n_light, safe_s_light, safe_e_light, safe_w_light;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_dir;
`ifdef TRAFFIC_FAULT_LOG_EN
    logic [7:0] fault_cnt;
`endif

    logic [17:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    traffic_conflict_monitor dut (
        .clk         (clk),
        .rst_a       (rst_a),
        .n_light     (n_light),
        .s_light     (s_light),
        .e_light     (e_light),
        .w_light     (w_light),
        .fault_clr   (fault_clr),
        .safe_n_light(safe_n_light),
        .safe_s_light(safe_s_light),
        .safe_e_light(safe_e_light),
        .safe_w_light(safe_w_light),
        .fault       (fault),
        .fault_code  (fault_code),
        .fault_dir   (fault_dir)
`ifdef TRAFFIC_FAULT_LOG_EN
        ,
        .fault_cnt   (fault_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    // Light vector {n, s, e, w} with a single approach a (0=N..3=W) set to c.
    function automatic logic [11:0] one(input int a, input logic [2:0] c);
        logic [11:0] v;
        v = '0;
        v[3*(3-a) +: 3] = c;
        return v;
    endfunction

    task automatic cyc(input string tag, input logic rst, input logic [11:0] lt,
                       input logic clr, input logic f, input logic [2:0] code,
                       input logic [1:0] dir, input logic [11:0] safe);
        logic [17:0] obs, exp_v;
        rst_a = rst;
        {n_light, s_light, e_light, w_light} = lt;
        fault_clr = clr;
        exp_q.push_back({f, code, dir, safe});
        @(posedge clk);
        #1;
        obs   = {fault, fault_code, fault_dir,
                 safe_n_light, safe_s_light, safe_e_light, safe_w_light};
        exp_v = exp_q.pop_front();
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: fault/code/dir/safe observed=%b/%0d/%0d/%h expected=%b/%0d/%0d/%h",
                   tag, obs[17], obs[16:14], obs[13:12], obs[11:0],
                   exp_v[17], exp_v[16:14], exp_v[13:12], exp_v[11:0]);
        end
    endtask

    // Two ARM cycles: inputs ignored, lights dark, no fault.
    task automatic arm(input logic [11:0] lt);
        cyc("arm_1", 1'b1, lt, 1'b0, 1'b0, 3'd0, 2'd0, 12'h000);
        cyc("arm_2", 1'b1, lt, 1'b0, 1'b0, 3'd0, 2'd0, 12'h000);
    endtask

    task automatic run_ok(input string tag, input logic [11:0] lt, input int n);
        for (int k = 0; k < n; k++) begin
            cyc(tag, 1'b1, lt, 1'b0, 1'b0, 3'd0, 2'd0, lt);
        end
    endtask

    task automatic clear_fault();
        cyc("clear", 1'b1, 12'h000, 1'b1, 1'b0, 3'd0, 2'd0, 12'h000);
    endtask

    initial begin
        rst_a = 1'b0;
        {n_light, s_light, e_light, w_light} = '0;
        fault_clr = 1'b0;

        cyc("reset_1", 1'b0, one(0, G), 1'b0, 1'b0, 3'd0, 2'd0, 12'h000);
        cyc("reset_2", 1'b0, 12'h000, 1'b0, 1'b0, 3'd0, 2'd0, 12'h000);
        arm(12'h000);

        // Two full legal rotations, including one-edge handovers.
        for (int r = 0; r < 2; r++) begin
            for (int a = 0; a < 4; a++) begin
                run_ok("rot_green", one(a, G), 8);
                run_ok("rot_yellow", one(a, Y), 4);
            end
        end

        cyc("conflict", 1'b1, one(0, G) | one(2, G), 1'b0, 1'b1, 3'd2, 2'd0, 12'h000);
        cyc("clr_nonred", 1'b1, one(3, G), 1'b1, 1'b1, 3'd2, 2'd0, 12'h000);
        clear_fault();

        // ARM must last exactly two cycles: a green arriving during ARM shows only after it.
        arm(one(0, G));
        run_ok("green_after_arm", one(0, G), 2);
        cyc("short_green", 1'b1, one(0, Y), 1'b0, 1'b1, 3'd4, 2'd0, 12'h000);
        clear_fault();

        // Green held exactly MIN_GREEN is legal; yellow held 2 is short.
        arm(12'h000);
        run_ok("green_min", one(0, G), 6);
        run_ok("yellow_short", one(0, Y), 2);
        cyc("short_yellow", 1'b1, 12'h000, 1'b0, 1'b1, 3'd5, 2'd0, 12'h000);
        clear_fault();

        arm(12'h000);
        run_ok("green_7", one(0, G), 7);
        cyc("seq_green_red", 1'b1, 12'h000, 1'b0, 1'b1, 3'd3, 2'd0, 12'h000);
        clear_fault();

        // Watchdog: 63 samples legal, the 64th identical sample trips STUCK.
        arm(one(0, G));
        run_ok("hold", one(0, G), 62);
        cyc("stuck", 1'b1, one(0, G), 1'b0, 1'b1, 3'd6, 2'd0, 12'h000);
        clear_fault();

        arm(12'h000);
        cyc("illegal", 1'b1, one(1, 3'b011) | one(2, G), 1'b0, 1'b1, 3'd1, 2'd1, 12'h000);
        cyc("first_wins", 1'b1, one(0, G) | one(3, G), 1'b0, 1'b1, 3'd1, 2'd1, 12'h000);
        cyc("clr_w_green", 1'b1, one(3, G), 1'b1, 1'b1, 3'd1, 2'd1, 12'h000);

        cyc("reset_mid_fault", 1'b0, one(3, G), 1'b0, 1'b0, 3'd0, 2'd0, 12'h000);
        cyc("arm_partial", 1'b1, one(0, G), 1'b0, 1'b0, 3'd0, 2'd0, 12'h000);
        cyc("reset_mid_arm", 1'b0, one(0, G), 1'b0, 1'b0, 3'd0, 2'd0, 12'h000);
        arm(one(0, G));
        run_ok("run_after_rearm", one(0, G), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_conflict_monitor.md
Name: traffic_conflict_monitor

Overview:
- Safety monitor on the receiving end of the four-approach light bus driven by the traffic signal controller.
- Samples n/s/e/w light codes every cycle and checks them for conflicting greens, illegal codes, bad colour sequences, short phases and stuck lights.
- On any violation it latches a fault and forces its registered pass-through lights to all-red until an operator clear.

Parameters:
MIN_GREEN, 6, minimum cycles a green must be held before changing.
MIN_YELLOW, 3, minimum cycles a yellow must be held before changing.
WDOG, 64, maximum cycles the light vector may stay unchanged.
ARM_DLY, 2, cycles after reset or re-arm during which checks are disabled.

Ports:
clk  input  1  system clock, rising edge.
rst_a  input  1  reset; synchronous, active-low (sampled on clk; 0 = reset).
n_light, s_light, e_light, w_light  input  3 each  light codes from the controller: 000 red, 001 green, 010 yellow; any other code is illegal.
fault_clr  input  1  operator clear request, level-sampled.
safe_n_light, safe_s_light, safe_e_light, safe_w_light  output  3 each  registered lights to the lamp drivers.
fault  output  1  latched fault flag.
fault_code  output  3  1 ILLEGAL, 2 CONFLICT, 3 SEQ, 4 SHORT_GREEN, 5 SHORT_YELLOW, 6 STUCK; 0 none.
fault_dir  output  2  offending approach: 0 N, 1 S, 2 E, 3 W.

Behaviour:
- Reset (rst_a=0 at a clk edge):
  - All safe_* outputs = 000; fault=0, fault_code=0, fault_dir=0.
  - State = ARM; previous-light registers = all red; duration counter = 0.
- FSM ARM:
  - safe_* forced to 000; input lights are ignored.
  - After ARM_DLY cycles go to RUN with prev := current inputs and duration := 1.
- FSM RUN:
  - safe_* = inputs registered, 1-cycle latency.
  - Duration counter increments while the 12-bit light vector equals prev; it saturates at WDOG.
  - On a vector change, the counter reloads to 1.
  - Checks run each cycle on current inputs vs prev:
    - ILLEGAL: any code not in {000, 001, 010}.
    - CONFLICT: more than one approach non-red.
    - SEQ: on any approach, green->red, yellow->green, or red->yellow.
    - SHORT_GREEN: an approach leaves green with duration < MIN_GREEN.
    - SHORT_YELLOW: an approach leaves yellow with duration < MIN_YELLOW.
    - STUCK: duration reaches WDOG.
- Fault capture:
  - On any violation, in the same edge: fault=1, code/dir latched, state -> FAULT.
  - The safe_* values registered on that edge are already 000.
  - Simultaneous violations resolve by priority ILLEGAL > CONFLICT > SEQ > SHORT_GREEN > SHORT_YELLOW > STUCK.
  - fault_dir = lowest-index offending approach; 0 for STUCK.
- FSM FAULT:
  - safe_* held at 000; fault, code and dir held.
  - Further violations are ignored; the first fault wins.
  - fault_clr=1 while all inputs are 000 -> state ARM and fault, code, dir cleared.
  - fault_clr while any input is non-red is ignored.
- Boundary conditions:
  - A legal handover in one edge (yellow->red on one approach, red->green on another) is not a conflict.
  - Reset has priority over everything, including mid-FAULT and mid-ARM.
  - Duration counter width = clog2(WDOG+1).

Optional Feature:
TRAFFIC_FAULT_LOG_EN:
- Defined: adds output fault_cnt (8-bit). It increments on each RUN->FAULT entry, saturates at 255, and is cleared only by reset, not by fault_clr.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared traffic_pkg holds:
  - light code constants RED/GREEN/YELLOW;
  - 3-bit fault code constants;
  - approach index constants N/S/E/W;
  - monitor state enum ARM/RUN/FAULT.
- One sub-module, light_seq_checker, instantiated four times. It takes prev/cur code and the shared duration and flags illegal, seq, short_green and short_yellow for one approach. Top level does conflict, stuck, priority and FSM.

Test Plan:
- Reset, then a legal controller cycle (N green 8 cycles, yellow 4, then S, E, W) for two full rotations -> fault stays 0; safe_* equal inputs delayed 1 cycle.
- In RUN, drive n=001 and e=001 in the same cycle -> next edge fault=1, fault_code=2, fault_dir=0, all safe_*=000.
- N green held 3 cycles then yellow -> fault_code=4, fault_dir=0; N green then straight to red -> fault_code=3.
- Hold the vector constant for 64 cycles -> fault_code=6 on the cycle the duration hits 64.
- s_light=011 together with e=001 -> fault_code=1 (ILLEGAL beats CONFLICT), fault_dir=1.
- In FAULT:
  - fault_clr=1 with w=001 -> no change.
  - fault_clr=1 with all 000 -> fault=0, ARM for 2 cycles, then RUN.
  - Assert rst_a=0 mid-FAULT -> all outputs 0 next edge.
